vis_centroid_calc: RTL
======================

VIS_CENTROID_CALC -- requirements
Module: vis_centroid_calc

Interface
REQ-001 SHALL have parameter IMG_H, default 720, active lines per frame.
REQ-002 SHALL have parameter IMG_W, default 1280, active pixels per line.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port de, input, 1 bit: active-video pixel strobe.
REQ-006 SHALL have port hsync, input, 1 bit: line sync; unused internally, accepted for bus uniformity.
REQ-007 SHALL have port vsync, input, 1 bit: frame sync, active high.
REQ-008 SHALL have port mask_in, input, 1 bit: 1 marks an object pixel; sampled when de=1.
REQ-009 SHALL have port x, output, 11 bits: centroid column, registered.
REQ-010 SHALL have port y, output, 11 bits: centroid row, registered.
REQ-011 SHALL have port valid, output, 1 bit: one-cycle pulse when x/y update.
REQ-012 SHALL have port no_obj, output, 1 bit: one-cycle pulse when a frame held no object pixel.
REQ-013 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-014 SHALL have port overrun, output, 1 bit: sticky flag, cleared only by reset.

Function
REQ-015 SHALL keep internal counters x_pos/y_pos, 11 bits each, cleared while vsync=1.
REQ-016 SHALL, on each de=1 cycle, increment x_pos, wrapping IMG_W-1 to 0 with y_pos+1, and wrapping y_pos IMG_H-1 to 0.
REQ-017 SHALL, on de=1 and mask_in=1, update m00+=1, m10+=x_pos and m01+=y_pos; all three are 32-bit unsigned and never overflow at the default geometry.
REQ-018 SHALL define frame end as the first clk edge that samples vsync=1 after an edge that sampled vsync=0.
REQ-019 SHALL, at frame end, snapshot m00/m10/m01 into divider registers and clear the accumulators in the same cycle.
REQ-020 SHALL implement the FSM IDLE->LOAD->DIV_X (32 cycles)->DIV_Y (32 cycles)->DONE->IDLE, using a restoring 32-bit serial divider that produces one quotient bit per cycle.
REQ-021 SHALL skip division if the snapshot m00 is 0: it goes LOAD->DONE, pulses no_obj, holds x/y and does not pulse valid.
REQ-022 SHALL, in DONE with m00>0, load x=m10/m00[10:0] and y=m01/m00[10:0] and pulse valid for exactly 1 cycle.
REQ-023 SHALL pulse valid 66 clk cycles after the frame-end edge (LOAD=1, DIV_X=32, DIV_Y=32, DONE=1).
REQ-024 SHALL assert busy in LOAD, DIV_X and DIV_Y.
REQ-025 SHALL treat a frame end while busy as follows: set overrun, discard the current division, re-snapshot, and restart at LOAD; x/y are unchanged.
REQ-026 SHALL hold x/y stable between valid pulses.

Reset
REQ-027 SHALL, while rst_n=0, immediately force x=0, y=0, valid=0, no_obj=0, busy=0, overrun=0, all accumulators and counters to 0, and the FSM to IDLE.
REQ-028 SHALL treat reset asserted mid-division as an abort: no valid pulse, and the next complete frame after release is computed normally.
REQ-029 SHALL not count a frame already in progress at reset release as a frame end unless vsync is first sampled 0.

Configuration
REQ-030 SHALL use macro CENTROID_ROUND_EN: when defined, the numerators become m10+(m00>>1) and m01+(m00>>1) (round half up); when undefined, the quotient truncates. Latency is identical in both builds.

Verification
REQ-031 SHALL test a single mask pixel at (100,50), then vsync: valid at +66 cycles with x=100, y=50.
REQ-032 SHALL test a rectangle covering columns 10-19 and rows 20-29: x=14, y=24 truncated; x=15, y=25 with CENTROID_ROUND_EN.
REQ-033 SHALL test a full-frame mask at 1280x720: x=639, y=359 truncated; x=640, y=360 with CENTROID_ROUND_EN.
REQ-034 SHALL test an empty frame after a valid (100,50) result: no_obj pulses, valid stays 0, x=100, y=50 held.
REQ-035 SHALL test rst_n low at cycle 20 of DIV_X: outputs 0, no valid; the next frame with a pixel at (5,7) gives x=5, y=7.
REQ-036 SHALL test a second vsync rise 10 cycles after frame end: overrun=1, and a single valid carrying the second frame's result.

Source files
------------

// File: rtl/vis_centroid_calc.sv
// Frame-level object centroid from a pixel mask; serial divide per frame.
// Define CENTROID_ROUND_EN for round-half-up quotients.
module vis_centroid_calc #(
  parameter int IMG_H = 720,
  parameter int IMG_W = 1280
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        de,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        mask_in,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic        valid,
  output logic        no_obj,
  output logic        busy,
  output logic        overrun
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DIV_X,
    S_DIV_Y,
    S_DONE
  } state_t;

  localparam logic [10:0] LP_XMAX = 11'(IMG_W - 1);
  localparam logic [10:0] LP_YMAX = 11'(IMG_H - 1);

  state_t      r_state;
  logic        r_vs_prev;
  logic [10:0] r_xpos;
  logic [10:0] r_ypos;
  logic [31:0] r_m00;
  logic [31:0] r_m10;
  logic [31:0] r_m01;
  logic [31:0] r_num_x;
  logic [31:0] r_num_y;
  logic [31:0] r_den;
  logic        r_zero;
  logic [31:0] r_quo;
  logic [31:0] r_rem;
  logic [4:0]  r_cnt;
  logic [10:0] r_qx;
  logic [10:0] r_qy;

  logic        w_fe;
  logic [31:0] w_nx;
  logic [31:0] w_ny;
  logic [32:0] w_sh;
  logic [32:0] w_sub;
  logic        w_ge;
  logic [31:0] w_rem_nx;
  logic [31:0] w_quo_nx;
  logic        w_unused_hsync;

  assign w_unused_hsync = hsync;
  assign w_fe = vsync & ~r_vs_prev;

`ifdef CENTROID_ROUND_EN
  assign w_nx = r_m10 + (r_m00 >> 1);
  assign w_ny = r_m01 + (r_m00 >> 1);
`else
  assign w_nx = r_m10;
  assign w_ny = r_m01;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_sh     = {r_rem, r_quo[31]};
  assign w_sub    = w_sh - {1'b0, r_den};
  assign w_ge     = (w_sh >= {1'b0, r_den});
  assign w_rem_nx = w_ge ? w_sub[31:0] : w_sh[31:0];
  assign w_quo_nx = {r_quo[30:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xpos <= '0;
      r_ypos <= '0;
    end else if (vsync) begin
      r_xpos <= '0;
      r_ypos <= '0;
    end else if (de) begin
      if (r_xpos == LP_XMAX) begin
        r_xpos <= '0;
        if (r_ypos == LP_YMAX) r_ypos <= '0;
        else r_ypos <= r_ypos + 11'd1;
      end else begin
        r_xpos <= r_xpos + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m00 <= '0;
      r_m10 <= '0;
      r_m01 <= '0;
    end else if (w_fe) begin
      r_m00 <= '0;
      r_m10 <= '0;
      r_m01 <= '0;
    end else if (de && mask_in) begin
      r_m00 <= r_m00 + 32'd1;
      r_m10 <= r_m10 + {21'd0, r_xpos};
      r_m01 <= r_m01 + {21'd0, r_ypos};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_vs_prev <= 1'b1;
      r_num_x   <= '0;
      r_num_y   <= '0;
      r_den     <= '0;
      r_zero    <= 1'b0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_cnt     <= '0;
      r_qx      <= '0;
      r_qy      <= '0;
      x         <= '0;
      y         <= '0;
      valid     <= 1'b0;
      no_obj    <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_vs_prev <= vsync;
      valid     <= 1'b0;
      no_obj    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
        end
        S_LOAD: begin
          r_quo <= r_num_x;
          r_rem <= '0;
          r_cnt <= '0;
          if (r_zero) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
          end else begin
            r_state <= S_DIV_X;
          end
        end
        S_DIV_X: begin
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) begin
            r_qx    <= w_quo_nx[10:0];
            r_quo   <= r_num_y;
            r_rem   <= '0;
            r_state <= S_DIV_Y;
          end else begin
            r_quo <= w_quo_nx;
            r_rem <= w_rem_nx;
          end
        end
        S_DIV_Y: begin
          r_cnt <= r_cnt + 5'd1;
          r_quo <= w_quo_nx;
          r_rem <= w_rem_nx;
          if (r_cnt == 5'd31) begin
            r_qy    <= w_quo_nx[10:0];
            r_state <= S_DONE;
            busy    <= 1'b0;
          end
        end
        S_DONE: begin
          if (r_zero) begin
            no_obj <= 1'b1;
          end else begin
            x     <= r_qx;
            y     <= r_qy;
            valid <= 1'b1;
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
      // A new frame end always wins: abandon any division and restart.
      if (w_fe) begin
        overrun <= overrun | busy;
        r_num_x <= w_nx;
        r_num_y <= w_ny;
        r_den   <= r_m00;
        r_zero  <= (r_m00 == 32'd0);
        r_state <= S_LOAD;
        busy    <= 1'b1;
      end
    end
  end

endmodule
